// File: rtl/ghost_pkg.sv
// Shared types and constants for the ghost sprite row renderer.
package ghost_pkg;

    localparam int SPRITE_W = 32;
    localparam int SPRITE_H = 32;
    localparam int SCREEN_W = 640;
    localparam int ROM_AW   = 8;

    localparam logic [1:0] GHOST_NORMAL = 2'd0;
    localparam logic [1:0] GHOST_FRIGHT = 2'd1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CAPTURE,
        ST_ARMED,
        ST_ACTIVE
    } ghost_state_t;

endpackage

// File: rtl/ghost_row_shifter.sv
// Holds one sprite row, optionally mirrored at load, and walks it MSB-first.
module ghost_row_shifter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load,
    input  logic         mirror,
    input  logic [W-1:0] data_in,
    input  logic         shift,
    output logic         bit_out,
    output logic         last
);
    localparam int CW = $clog2(W);

    logic [W-1:0]  row_q;
    logic [W-1:0]  mirrored;
    logic [CW-1:0] cnt_q;

    // Bit-reversed copy of the incoming ROM word for left-facing sprites.
    always_comb begin
        mirrored = '0;
        for (int i = 0; i < W; i++) begin
            mirrored[i] = data_in[W-1-i];
        end
    end

    // Row register and column counter; the leftmost pixel is always bit W-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            cnt_q <= '0;
        end else if (clear) begin
            row_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            row_q <= mirror ? mirrored : data_in;
            cnt_q <= '0;
        end else if (shift) begin
            row_q <= {row_q[W-2:0], 1'b0};
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign bit_out = row_q[W-1];
    assign last    = (cnt_q == CW'(W - 1));

endmodule

// File: rtl/ghost_row_renderer.sv
// Fetches one ghost sprite row per hblank and serialises it across the ghost's X span.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | nothing to draw on this line (or line already finished)
//   FETCH    | ROM read outstanding, waiting out the ROM latency
//   CAPTURE  | ROM word valid; latch it (mirrored if facing left)
//   ARMED    | row latched, waiting for DrawX to hit the ghost's left edge
//   ACTIVE   | emitting one sprite column per pixel strobe
module ghost_row_renderer #(
    parameter int SPRITE_W = 32,
    parameter int SPRITE_H = 32,
    parameter int ROM_BASE = 0,
    parameter int ROM_LAT  = 0
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         pix_en,
    input  logic                         line_start,
    input  logic [9:0]                   next_y,
    input  logic [9:0]                   DrawX,
    input  logic [9:0]                   ghost_x,
    input  logic [9:0]                   ghost_y,
    input  logic                         facing_left,
    input  logic                         frightened,
    output logic [ghost_pkg::ROM_AW-1:0] rom_addr,
    output logic                         rom_rd,
    input  logic [SPRITE_W-1:0]          rom_data,
    output logic                         ghost_on,
    output logic [1:0]                   ghost_color,
    output logic                         busy
);
    import ghost_pkg::*;

    // A zero-latency ROM still gets one FETCH cycle so CAPTURE sees settled data.
    localparam int         FETCH_CYC  = (ROM_LAT == 0) ? 1 : ROM_LAT;
    localparam logic [1:0] FETCH_LOAD = 2'(FETCH_CYC - 1);
    localparam int         ROW_AW     = $clog2(SPRITE_H);

    ghost_state_t state_q, state_nx;

    logic [9:0]        gx_q;
    logic              fl_q;
    logic              fr_q;
    logic [1:0]        fcnt_q;

    logic signed [10:0] row_s;
    logic               row_hit;
    logic [ROM_AW-1:0]  rom_row;

    logic fetch_go;
    logic clr_row;
    logic load_row;
    logic shift_row;
    logic emit;
    logic blank;
    logic row_bit;
    logic row_last;

    // Sprite row for the upcoming scanline; negative means the ghost starts lower.
    assign row_s   = $signed({1'b0, next_y}) - $signed({1'b0, ghost_y});
    assign row_hit = !row_s[10] && (row_s[9:0] < 10'(SPRITE_H));
    assign rom_row = ROM_AW'(ROM_BASE) + ROM_AW'(row_s[ROW_AW-1:0]);

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    // Next-state and per-cycle control strobes; line_start overrides everything.
    always_comb begin
        state_nx  = state_q;
        fetch_go  = 1'b0;
        clr_row   = 1'b0;
        load_row  = 1'b0;
        shift_row = 1'b0;
        emit      = 1'b0;
        if (line_start) begin
            if (row_hit) begin
                fetch_go = 1'b1;
                state_nx = ST_FETCH;
            end else begin
                clr_row  = 1'b1;
                state_nx = ST_IDLE;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_nx = ST_IDLE;
                end
                ST_FETCH: begin
                    if (fcnt_q == 2'd0) begin
                        state_nx = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    load_row = 1'b1;
                    state_nx = ST_ARMED;
                end
                ST_ARMED: begin
                    // The matching strobe already carries column 0.
                    if (pix_en && (DrawX == gx_q)) begin
                        emit      = 1'b1;
                        shift_row = 1'b1;
                        state_nx  = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (pix_en) begin
                        emit      = 1'b1;
                        shift_row = 1'b1;
                        if (row_last) begin
                            state_nx = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

    // Any strobe that does not emit a sprite column, and every line_start, blanks the pixel.
    assign blank = line_start || (pix_en && !emit);

    // Line parameters, ROM handshake and registered pixel outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            gx_q        <= '0;
            fl_q        <= 1'b0;
            fr_q        <= 1'b0;
            fcnt_q      <= '0;
            rom_addr    <= '0;
            rom_rd      <= 1'b0;
            ghost_on    <= 1'b0;
            ghost_color <= GHOST_NORMAL;
        end else begin
            if (line_start) begin
                gx_q <= ghost_x;
                fl_q <= facing_left;
                fr_q <= frightened;
            end

            if (fetch_go) begin
                rom_addr <= rom_row;
                rom_rd   <= 1'b1;
                fcnt_q   <= FETCH_LOAD;
            end else if (line_start) begin
                rom_rd <= 1'b0;
            end else if (state_q == ST_FETCH) begin
                if (fcnt_q == 2'd0) begin
                    rom_rd <= 1'b0;
                end else begin
                    fcnt_q <= fcnt_q - 2'd1;
                end
            end

            if (emit) begin
                ghost_on    <= row_bit;
                ghost_color <= fr_q ? GHOST_FRIGHT : GHOST_NORMAL;
            end else if (blank) begin
                ghost_on <= 1'b0;
            end
        end
    end

    ghost_row_shifter #(
        .W (SPRITE_W)
    ) u_shifter (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .clear   (clr_row),
        .load    (load_row),
        .mirror  (fl_q),
        .data_in (rom_data),
        .shift   (shift_row),
        .bit_out (row_bit),
        .last    (row_last)
    );

    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ghost_row_renderer.sv
// Self-checking bench: two renderers (ROM latency 0 and 2) driven by the same raster.
module tb_ghost_row_renderer;

    logic        clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        pix_en = 1'b0;
    logic        line_start = 1'b0;
    logic [9:0]  next_y = '0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  ghost_x = '0;
    logic [9:0]  ghost_y = '0;
    logic        facing_left = 1'b0;
    logic        frightened = 1'b0;

    logic [7:0]  rom_addr0, rom_addr2;
    logic        rom_rd0, rom_rd2;
    logic [31:0] rom_data0, rom_data2;
    logic        ghost_on0, ghost_on2;
    logic [1:0]  ghost_color0, ghost_color2;
    logic        busy0, busy2;

    logic [31:0] rom [0:255];
    logic [7:0]  a1 = '0;
    logic [7:0]  a2 = '0;

    int total = 0;
    int bad = 0;

    // observations gathered by the stimulus helpers
    logic [639:0] obs0, obs2;
    logic [1:0]   oc0 [0:639];
    logic [1:0]   oc2 [0:639];
    int           hold_bad0, hold_bad2;
    int           rd0, rd2;
    logic [7:0]   addr0, addr2;
    logic         ls_on0, ls_on2;
    logic         ls_rd0, ls_rd2;
    logic [7:0]   ls_addr0, ls_addr2;

    always #5 clk = ~clk;

    assign rom_data0 = rom[rom_addr0];
    always @(posedge clk) begin
        a1 <= rom_addr2;
        a2 <= a1;
    end
    assign rom_data2 = rom[a2];

    ghost_row_renderer #(.ROM_LAT(0)) dut0 (
        .Clk(clk), .Reset_n(Reset_n), .pix_en(pix_en), .line_start(line_start),
        .next_y(next_y), .DrawX(DrawX), .ghost_x(ghost_x), .ghost_y(ghost_y),
        .facing_left(facing_left), .frightened(frightened),
        .rom_addr(rom_addr0), .rom_rd(rom_rd0), .rom_data(rom_data0),
        .ghost_on(ghost_on0), .ghost_color(ghost_color0), .busy(busy0)
    );

    ghost_row_renderer #(.ROM_LAT(2)) dut2 (
        .Clk(clk), .Reset_n(Reset_n), .pix_en(pix_en), .line_start(line_start),
        .next_y(next_y), .DrawX(DrawX), .ghost_x(ghost_x), .ghost_y(ghost_y),
        .facing_left(facing_left), .frightened(frightened),
        .rom_addr(rom_addr2), .rom_rd(rom_rd2), .rom_data(rom_data2),
        .ghost_on(ghost_on2), .ghost_color(ghost_color2), .busy(busy2)
    );

    // Reference: which screen columns of a line are lit for a given ghost placement.
    function automatic logic [639:0] model_line(input int ny, input int gx, input int gy, input bit fl);
        logic [639:0] v;
        logic [31:0]  w;
        int           row;
        v   = '0;
        row = ny - gy;
        if (row >= 0 && row < 32) begin
            w = rom[row];
            for (int c = 0; c < 32; c++) begin
                if (gx + c < 640) v[gx + c] = fl ? w[c] : w[31 - c];
            end
        end
        return v;
    endfunction

    function automatic logic [639:0] span(input int lo, input int hi);
        logic [639:0] v;
        v = '0;
        for (int x = lo; x <= hi; x++) v[x] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_ghost();
        ghost_x     = 10'($urandom_range(0, 1023));
        ghost_y     = 10'($urandom_range(0, 1023));
        facing_left = 1'($urandom_range(0, 1));
        frightened  = 1'($urandom_range(0, 1));
    endtask

    // Issue line_start, then six hblank cycles counting ROM reads; ghost inputs are scrambled afterwards.
    task automatic start_line(input int ny, input int gx, input int gy, input bit fl, input bit fr, input bit pe);
        next_y      = 10'(ny);
        ghost_x     = 10'(gx);
        ghost_y     = 10'(gy);
        facing_left = fl;
        frightened  = fr;
        DrawX       = 10'(gx);
        pix_en      = pe;
        line_start  = 1'b1;
        tick();
        line_start = 1'b0;
        pix_en     = 1'b0;
        ls_on0 = ghost_on0;  ls_on2 = ghost_on2;
        ls_rd0 = rom_rd0;    ls_rd2 = rom_rd2;
        ls_addr0 = rom_addr0; ls_addr2 = rom_addr2;
        rd0 = 0; rd2 = 0; addr0 = '0; addr2 = '0;
        for (int i = 0; i < 6; i++) begin
            if (rom_rd0) begin rd0++; addr0 = rom_addr0; end
            if (rom_rd2) begin rd2++; addr2 = rom_addr2; end
            scramble_ghost();
            tick();
        end
    endtask

    // Strobe DrawX over [x_from, x_to] every other cycle, recording outputs and hold behaviour.
    task automatic sweep(input int x_from, input int x_to);
        obs0 = '0; obs2 = '0; hold_bad0 = 0; hold_bad2 = 0;
        for (int x = 0; x < 640; x++) begin oc0[x] = 2'd0; oc2[x] = 2'd0; end
        for (int x = x_from; x <= x_to; x++) begin
            DrawX  = 10'(x);
            pix_en = 1'b1;
            tick();
            obs0[x] = ghost_on0; obs2[x] = ghost_on2;
            oc0[x]  = ghost_color0; oc2[x] = ghost_color2;
            pix_en = 1'b0;
            DrawX  = 10'($urandom_range(0, 1023));
            scramble_ghost();
            tick();
            if (ghost_on0 !== obs0[x]) hold_bad0++;
            if (ghost_on2 !== obs2[x]) hold_bad2++;
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        #3;
        total++;
        if ({rom_addr0, rom_rd0, ghost_on0, ghost_color0, busy0} !== 13'd0) begin
            bad++; $display("FAIL reset_dut0 got=%h exp=0", {rom_addr0, rom_rd0, ghost_on0, ghost_color0, busy0});
        end
        total++;
        if ({rom_addr2, rom_rd2, ghost_on2, ghost_color2, busy2} !== 13'd0) begin
            bad++; $display("FAIL reset_dut2 got=%h exp=0", {rom_addr2, rom_rd2, ghost_on2, ghost_color2, busy2});
        end
        tick(); tick();
        #2 Reset_n = 1'b1;
        tick();
    endtask

    task automatic test_row5();
        logic [639:0] exp_v;
        exp_v = span(111, 121);
        start_line(55, 100, 50, 1'b0, 1'b0, 1'b0);
        total++;
        if (rd0 !== 1 || addr0 !== 8'd5) begin
            bad++; $display("FAIL row5_fetch_lat0 got rd_cycles=%0d addr=%0d exp 1/5", rd0, addr0);
        end
        total++;
        if (rd2 !== 2 || addr2 !== 8'd5) begin
            bad++; $display("FAIL row5_fetch_lat2 got rd_cycles=%0d addr=%0d exp 2/5", rd2, addr2);
        end
        sweep(0, 639);
        total++;
        if (obs0 !== exp_v) begin bad++; $display("FAIL row5_pixels_dut0 got=%h exp=%h", obs0, exp_v); end
        total++;
        if (obs2 !== exp_v) begin bad++; $display("FAIL row5_pixels_dut2 got=%h exp=%h", obs2, exp_v); end
        total++;
        if (hold_bad0 !== 0 || hold_bad2 !== 0) begin
            bad++; $display("FAIL row5_hold got=%0d/%0d exp=0/0", hold_bad0, hold_bad2);
        end
        total++;
        if (busy0 !== 1'b0 || busy2 !== 1'b0) begin
            bad++; $display("FAIL row5_busy_end got=%b%b exp=00", busy0, busy2);
        end
    endtask

    task automatic test_mirror();
        logic [639:0] exp_v;
        int cbad;
        exp_v = span(110, 120);
        start_line(55, 100, 50, 1'b1, 1'b1, 1'b0);
        sweep(0, 639);
        total++;
        if (obs0 !== exp_v) begin bad++; $display("FAIL mirror_pixels_dut0 got=%h exp=%h", obs0, exp_v); end
        total++;
        if (obs2 !== exp_v) begin bad++; $display("FAIL mirror_pixels_dut2 got=%h exp=%h", obs2, exp_v); end
        cbad = 0;
        for (int x = 110; x <= 120; x++) begin
            if (oc0[x] !== 2'd1) cbad++;
            if (oc2[x] !== 2'd1) cbad++;
        end
        total++;
        if (cbad !== 0) begin bad++; $display("FAIL mirror_fright_color got=%0d bad pixels exp=0", cbad); end
    endtask

    task automatic test_out_of_range();
        int ys [2];
        ys[0] = 49; ys[1] = 82;
        for (int k = 0; k < 2; k++) begin
            start_line(ys[k], 100, 50, 1'b0, 1'b0, 1'b0);
            sweep(0, 639);
            total++;
            if (rd0 !== 0 || rd2 !== 0) begin
                bad++; $display("FAIL oor_rom_rd y=%0d got=%0d/%0d exp=0/0", ys[k], rd0, rd2);
            end
            total++;
            if (obs0 !== '0 || obs2 !== '0 || busy0 !== 1'b0 || busy2 !== 1'b0) begin
                bad++; $display("FAIL oor_line_dark y=%0d got=%h busy=%b%b exp=0", ys[k], obs0 | obs2, busy0, busy2);
            end
        end
    endtask

    task automatic test_latency_row13();
        logic [639:0] exp_v;
        exp_v = span(104, 108) | span(113, 119) | span(124, 127);
        start_line(55, 100, 50, 1'b0, 1'b0, 1'b0);
        sweep(0, 200);
        start_line(63, 100, 50, 1'b0, 1'b0, 1'b0);
        total++;
        if (rd2 !== 2 || addr2 !== 8'd13) begin
            bad++; $display("FAIL row13_fetch_lat2 got rd_cycles=%0d addr=%0d exp 2/13", rd2, addr2);
        end
        sweep(0, 639);
        total++;
        if (obs2 !== exp_v) begin bad++; $display("FAIL row13_eyes_dut2 got=%h exp=%h", obs2, exp_v); end
        total++;
        if (obs0 !== exp_v) begin bad++; $display("FAIL row13_eyes_dut0 got=%h exp=%h", obs0, exp_v); end
    endtask

    task automatic test_abort();
        logic [639:0] exp_v;
        start_line(57, 100, 50, 1'b0, 1'b0, 1'b0);
        sweep(0, 109);
        total++;
        if (ghost_on0 !== 1'b1 || ghost_on2 !== 1'b1) begin
            bad++; $display("FAIL abort_precondition got=%b%b exp=11", ghost_on0, ghost_on2);
        end
        start_line(63, 100, 50, 1'b0, 1'b0, 1'b1);
        total++;
        if (ls_on0 !== 1'b0 || ls_on2 !== 1'b0) begin
            bad++; $display("FAIL abort_drop got=%b%b exp=00", ls_on0, ls_on2);
        end
        total++;
        if (ls_rd0 !== 1'b1 || ls_rd2 !== 1'b1 || ls_addr0 !== 8'd13 || ls_addr2 !== 8'd13) begin
            bad++; $display("FAIL abort_refetch got rd=%b%b addr=%0d/%0d exp rd=11 addr=13", ls_rd0, ls_rd2, ls_addr0, ls_addr2);
        end
        exp_v = model_line(63, 100, 50, 1'b0);
        sweep(0, 639);
        total++;
        if (obs0 !== exp_v || obs2 !== exp_v) begin
            bad++; $display("FAIL abort_next_line got=%h/%h exp=%h", obs0, obs2, exp_v);
        end
    endtask

    task automatic test_clip();
        logic [639:0] exp_v;
        exp_v = model_line(70, 620, 50, 1'b0);
        start_line(70, 620, 50, 1'b0, 1'b0, 1'b0);
        sweep(0, 639);
        total++;
        if (obs0 !== exp_v || obs2 !== exp_v) begin
            bad++; $display("FAIL clip_pixels got=%h/%h exp=%h", obs0, obs2, exp_v);
        end
        total++;
        if (busy0 !== 1'b1 || busy2 !== 1'b1) begin
            bad++; $display("FAIL clip_busy_held got=%b%b exp=11", busy0, busy2);
        end
        start_line(10, 100, 50, 1'b0, 1'b0, 1'b0);
        total++;
        if (busy0 !== 1'b0 || busy2 !== 1'b0) begin
            bad++; $display("FAIL clip_busy_released got=%b%b exp=00", busy0, busy2);
        end
    endtask

    task automatic test_reset_midline();
        start_line(55, 100, 50, 1'b0, 1'b1, 1'b0);
        sweep(0, 115);
        #2 Reset_n = 1'b0;
        #1;
        total++;
        if ({rom_addr0, rom_rd0, ghost_on0, ghost_color0, busy0, rom_addr2, rom_rd2, ghost_on2, ghost_color2, busy2} !== 26'd0) begin
            bad++; $display("FAIL async_reset_outputs got on=%b%b busy=%b%b color=%0d/%0d exp=0", ghost_on0, ghost_on2, busy0, busy2, ghost_color0, ghost_color2);
        end
        tick(); tick();
        #2 Reset_n = 1'b1;
        tick();
        sweep(0, 639);
        total++;
        if (obs0 !== '0 || obs2 !== '0 || busy0 !== 1'b0 || busy2 !== 1'b0) begin
            bad++; $display("FAIL reset_stays_dark got=%h busy=%b%b exp=0", obs0 | obs2, busy0, busy2);
        end
    endtask

    task automatic test_random_lines();
        for (int n = 0; n < 12; n++) begin
            int gx, gy, ny, row, cbad;
            bit fl, fr, hit;
            logic [639:0] exp_v;
            gy = $urandom_range(0, 400);
            ny = gy + $urandom_range(0, 40) - 4;
            if (ny < 0) ny = 0;
            gx = ($urandom_range(0, 7) == 0) ? $urandom_range(640, 700) : $urandom_range(0, 639);
            fl = 1'($urandom_range(0, 1));
            fr = 1'($urandom_range(0, 1));
            row = ny - gy;
            hit = (row >= 0 && row < 32);
            exp_v = model_line(ny, gx, gy, fl);
            start_line(ny, gx, gy, fl, fr, 1'($urandom_range(0, 1)));
            total++;
            if (rd0 !== (hit ? 1 : 0) || rd2 !== (hit ? 2 : 0)) begin
                bad++; $display("FAIL rand_fetch_count n=%0d got=%0d/%0d hit=%0d", n, rd0, rd2, hit);
            end
            if (hit) begin
                total++;
                if (addr0 !== 8'(row) || addr2 !== 8'(row)) begin
                    bad++; $display("FAIL rand_rom_addr n=%0d got=%0d/%0d exp=%0d", n, addr0, addr2, row);
                end
            end
            sweep(0, 639);
            total++;
            if (obs0 !== exp_v) begin bad++; $display("FAIL rand_pixels_dut0 n=%0d got=%h exp=%h", n, obs0, exp_v); end
            total++;
            if (obs2 !== exp_v) begin bad++; $display("FAIL rand_pixels_dut2 n=%0d got=%h exp=%h", n, obs2, exp_v); end
            cbad = 0;
            for (int x = 0; x < 640; x++) begin
                if (exp_v[x] && oc0[x] !== {1'b0, fr}) cbad++;
                if (exp_v[x] && oc2[x] !== {1'b0, fr}) cbad++;
            end
            total++;
            if (cbad !== 0) begin bad++; $display("FAIL rand_color n=%0d got=%0d bad pixels exp=0", n, cbad); end
            total++;
            if (hold_bad0 !== 0 || hold_bad2 !== 0) begin
                bad++; $display("FAIL rand_hold n=%0d got=%0d/%0d exp=0/0", n, hold_bad0, hold_bad2);
            end
            total++;
            if (busy0 !== (hit && gx + 31 > 639) || busy2 !== (hit && gx + 31 > 639)) begin
                bad++; $display("FAIL rand_busy_end n=%0d got=%b%b exp=%0d", n, busy0, busy2, hit && gx + 31 > 639);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = $urandom;
        rom[5]  = 32'b00000000000111111111110000000000;
        rom[7]  = 32'b11111111110000000000000000000000;
        rom[13] = 32'b00001111100001111111000011110000;
        test_reset();
        test_row5();
        test_mirror();
        test_out_of_range();
        test_latency_row13();
        test_abort();
        test_clip();
        test_reset_midline();
        test_random_lines();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
